multicycle_controller: RTL and testbench

Multi-cycle sequencer for the RV32I core. It replaces the single-cycle decode with an FSM that steps the shared datapath (one ALU, one unified memory port, IR/ALUOut/OldPC registers) through fetch, decode, execute, memory and writeback. It drives all datapath enables and mux selects, owns the memory request handshake with a timeout counter, and traps on illegal encodings or bus timeouts.

---
 rtl/multicycle_controller.sv | 247 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: steps the shared datapath through fetch/decode/execute/memory/writeback
// and owns the memory handshake, with a bus-timeout watchdog and sticky trap.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] fun3,
  input  logic [6:0] fun7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUSel,
  output logic [2:0] ImmSel,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_U, S_WB_ALU, S_MEM_ADR,
    S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JALR_ADR, S_JUMP, S_TRAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [1:0]    cause_q, cause_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    cause_d    = cause_q;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUSel     = ALU_ADD;
    ImmSel     = IMM_I;
    trap       = 1'b0;
    trap_cause = cause_q;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSel  = (op == 7'b1101111) ? IMM_J : IMM_B;
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEM_ADR;
          7'b0110011:             state_d = S_EXEC_R;
          7'b0010011:             state_d = S_EXEC_I;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JUMP;
          7'b1100111:             state_d = S_JALR_ADR;
          7'b0110111, 7'b0010111: state_d = S_EXEC_U;
          default: begin
            state_d = S_TRAP;
            cause_d = 2'b01;
          end
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b10;
        state_d = S_WB_ALU;
        case (fun3)
          3'b000:  ALUSel = (fun7 == 7'h20) ? ALU_SUB : ALU_ADD;
          3'b001:  ALUSel = ALU_SLL;
          3'b010:  ALUSel = ALU_SLT;
          3'b011:  ALUSel = ALU_SLTU;
          3'b100:  ALUSel = ALU_XOR;
          3'b101:  ALUSel = (fun7 == 7'h20) ? ALU_SRA : ALU_SRL;
          3'b110:  ALUSel = ALU_OR;
          default: ALUSel = ALU_AND;
        endcase
        // Only 0x20 is a legal modifier, and only on ADD/SRL.
        if ((fun7 != 7'h00 && fun7 != 7'h20) ||
            (fun7 == 7'h20 && fun3 != 3'b000 && fun3 != 3'b101)) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSel  = IMM_I;
        state_d = S_WB_ALU;
        case (fun3)
          3'b000:  ALUSel = ALU_ADD;
          3'b001:  ALUSel = ALU_SLL;
          3'b010:  ALUSel = ALU_SLT;
          3'b011:  ALUSel = ALU_SLTU;
          3'b100:  ALUSel = ALU_XOR;
          3'b101:  ALUSel = (fun7 == 7'h20) ? ALU_SRA : ALU_SRL;
          3'b110:  ALUSel = ALU_OR;
          default: ALUSel = ALU_AND;
        endcase
        if ((fun3 == 3'b001 && fun7 != 7'h00) ||
            (fun3 == 3'b101 && fun7 != 7'h00 && fun7 != 7'h20)) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_EXEC_U: begin
        ALUSrcA = op[5] ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
        ImmSel  = IMM_U;
        state_d = S_WB_ALU;
      end
      S_WB_ALU: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_ADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSel  = op[5] ? IMM_S : IMM_I;
        state_d = op[5] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_WB_MEM: begin
        RegWrite  = 1'b1;
        ResultSrc = 2'b01;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        state_d = S_FETCH;
        case (fun3)
          3'b000: begin ALUSel = ALU_SUB;  PCWrite = zero;  end
          3'b001: begin ALUSel = ALU_SUB;  PCWrite = !zero; end
          3'b100: begin ALUSel = ALU_SLT;  PCWrite = !zero; end
          3'b101: begin ALUSel = ALU_SLT;  PCWrite = zero;  end
          3'b110: begin ALUSel = ALU_SLTU; PCWrite = !zero; end
          3'b111: begin ALUSel = ALU_SLTU; PCWrite = zero;  end
          default: begin
            state_d = S_TRAP;
            cause_d = 2'b01;
          end
        endcase
      end
      S_JALR_ADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JUMP;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        state_d = S_WB_ALU;
      end
      default: trap = 1'b1;
    endcase

    // Watchdog on the memory handshake; a same-cycle mem_ready has already advanced state_d.
    if ((state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR) && !mem_ready) begin
      if (wait_q == WAIT_LAST) begin
        state_d = S_TRAP;
        cause_d = 2'b10;
      end else begin
        wait_d = wait_q + CW'(1);
      end
    end
    if (state_d != state_q) wait_d = '0;

    if (!rst_n) begin
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUSel     = ALU_ADD;
      ImmSel     = IMM_I;
      trap       = 1'b0;
      trap_cause = 2'b00;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: drives instruction fields per cycle and compares the
// packed control vector against hand-derived per-state expectations.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] fun3;
  logic [6:0] fun7;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, MemWrite, RegWrite, IRWrite, PCWrite, AdrSrc, trap;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, trap_cause;
  logic [3:0] ALUSel;
  logic [2:0] ImmSel;
  logic [21:0] outVec;

  int checkCount = 0;
  int errorCount = 0;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BAD  = 7'b0000000;

  multicycle_controller #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .fun3(fun3), .fun7(fun7), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUSel(ALUSel), .ImmSel(ImmSel),
    .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  assign outVec = {mem_req, MemWrite, RegWrite, IRWrite, PCWrite, AdrSrc, ResultSrc,
                   ALUSrcA, ALUSrcB, ALUSel, ImmSel, trap, trap_cause};

  function automatic logic [21:0] packOut(input logic mreq, input logic mw, input logic rw,
                                          input logic irw, input logic pcw, input logic adr,
                                          input logic [1:0] res, input logic [1:0] srca,
                                          input logic [1:0] srcb, input logic [3:0] alu,
                                          input logic [2:0] imm, input logic trp,
                                          input logic [1:0] cause);
    return {mreq, mw, rw, irw, pcw, adr, res, srca, srcb, alu, imm, trp, cause};
  endfunction

  function automatic logic [21:0] expFetch(input logic rdy);
    return packOut(1, 0, 0, rdy, rdy, 0, 2'b10, 2'b00, 2'b10, 4'b0000, 3'b000, 0, 2'b00);
  endfunction

  function automatic logic [21:0] expDecode(input logic isJal);
    return packOut(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'b0000,
                   isJal ? 3'b100 : 3'b010, 0, 2'b00);
  endfunction

  function automatic logic [21:0] expExecR(input logic [3:0] alu);
    return packOut(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 3'b000, 0, 2'b00);
  endfunction

  function automatic logic [21:0] expExecI(input logic [3:0] alu);
    return packOut(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 3'b000, 0, 2'b00);
  endfunction

  function automatic logic [21:0] expWbAlu();
    return packOut(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0, 2'b00);
  endfunction

  function automatic logic [21:0] expBranch(input logic [3:0] alu, input logic pcw);
    return packOut(0, 0, 0, 0, pcw, 0, 2'b00, 2'b10, 2'b00, alu, 3'b000, 0, 2'b00);
  endfunction

  function automatic logic [21:0] expTrap(input logic [1:0] cause);
    return packOut(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 1, cause);
  endfunction

  // Inputs change just after the falling edge and outputs are sampled 1ns later.
  task automatic applyStimulus(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                               input logic [6:0] f7, input logic z, input logic rdy);
    @(negedge clk);
    rst_n     = rst;
    op        = o;
    fun3      = f3;
    fun7      = f7;
    zero      = z;
    mem_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [21:0] observed,
                             input logic [21:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    applyStimulus(0, OP_R, 3'b000, 7'h00, 0, 1);
    applyStimulus(0, OP_R, 3'b000, 7'h00, 0, 1);
    checkOutput("reset.zero", outVec, 22'd0);
  endtask

  task automatic runAluInstr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [21:0] execExp);
    applyStimulus(1, o, f3, f7, 0, 1);
    checkOutput({tag, ".fetch"}, outVec, expFetch(1));
    applyStimulus(1, o, f3, f7, 0, 1);
    checkOutput({tag, ".decode"}, outVec, expDecode(0));
    applyStimulus(1, o, f3, f7, 0, 1);
    checkOutput({tag, ".exec"}, outVec, execExp);
    applyStimulus(1, o, f3, f7, 0, 1);
    checkOutput({tag, ".wb"}, outVec, expWbAlu());
  endtask

  task automatic runBranch(input string tag, input logic [2:0] f3, input logic z,
                           input logic [21:0] brExp);
    applyStimulus(1, OP_BR, f3, 7'h00, z, 1);
    checkOutput({tag, ".fetch"}, outVec, expFetch(1));
    applyStimulus(1, OP_BR, f3, 7'h00, z, 1);
    checkOutput({tag, ".decode"}, outVec, expDecode(0));
    applyStimulus(1, OP_BR, f3, 7'h00, z, 1);
    checkOutput({tag, ".branch"}, outVec, brExp);
  endtask

  initial begin
    rst_n = 0; op = OP_R; fun3 = 0; fun7 = 0; zero = 0; mem_ready = 1;
    doReset();

    runAluInstr("add",  OP_R, 3'b000, 7'h00, expExecR(4'b0000));
    runAluInstr("sub",  OP_R, 3'b000, 7'h20, expExecR(4'b1000));
    runAluInstr("srai", OP_I, 3'b101, 7'h20, expExecI(4'b0101));
    runAluInstr("srli", OP_I, 3'b101, 7'h00, expExecI(4'b1101));

    // Load with three wait states in MEM_RD.
    applyStimulus(1, OP_LD, 3'b010, 7'h00, 0, 1);
    checkOutput("lw.fetch", outVec, expFetch(1));
    applyStimulus(1, OP_LD, 3'b010, 7'h00, 0, 1);
    checkOutput("lw.decode", outVec, expDecode(0));
    applyStimulus(1, OP_LD, 3'b010, 7'h00, 0, 1);
    checkOutput("lw.adr", outVec, expExecI(4'b0000));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, OP_LD, 3'b010, 7'h00, 0, (i == 3));
      checkOutput($sformatf("lw.rd%0d", i), outVec,
                  packOut(1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0, 2'b00));
    end
    applyStimulus(1, OP_LD, 3'b010, 7'h00, 0, 1);
    checkOutput("lw.wbmem", outVec,
                packOut(0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 4'b0000, 3'b000, 0, 2'b00));

    applyStimulus(1, OP_ST, 3'b010, 7'h00, 0, 1);
    checkOutput("sw.fetch", outVec, expFetch(1));
    applyStimulus(1, OP_ST, 3'b010, 7'h00, 0, 1);
    checkOutput("sw.decode", outVec, expDecode(0));
    applyStimulus(1, OP_ST, 3'b010, 7'h00, 0, 1);
    checkOutput("sw.adr", outVec,
                packOut(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'b0000, 3'b001, 0, 2'b00));
    applyStimulus(1, OP_ST, 3'b010, 7'h00, 0, 1);
    checkOutput("sw.wr", outVec,
                packOut(1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0, 2'b00));

    runBranch("beq",  3'b000, 1, expBranch(4'b1000, 1));
    runBranch("bne",  3'b001, 1, expBranch(4'b1000, 0));
    runBranch("bltu", 3'b110, 0, expBranch(4'b0011, 1));
    runBranch("bge",  3'b101, 1, expBranch(4'b0010, 1));

    applyStimulus(1, OP_JAL, 3'b000, 7'h00, 0, 1);
    checkOutput("jal.fetch", outVec, expFetch(1));
    applyStimulus(1, OP_JAL, 3'b000, 7'h00, 0, 1);
    checkOutput("jal.decode", outVec, expDecode(1));
    applyStimulus(1, OP_JAL, 3'b000, 7'h00, 0, 1);
    checkOutput("jal.jump", outVec,
                packOut(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 4'b0000, 3'b000, 0, 2'b00));
    applyStimulus(1, OP_JAL, 3'b000, 7'h00, 0, 1);
    checkOutput("jal.wb", outVec, expWbAlu());

    // mem_ready arriving in the 16th waiting cycle must beat the timeout.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1, OP_R, 3'b000, 7'h00, 0, (i == 16));
      if (i == 1 || i >= 15) checkOutput($sformatf("late.fetch%0d", i), outVec, expFetch(i == 16));
    end
    applyStimulus(1, OP_R, 3'b000, 7'h00, 0, 1);
    checkOutput("late.decode", outVec, expDecode(0));
    applyStimulus(1, OP_R, 3'b000, 7'h00, 0, 1);
    applyStimulus(1, OP_R, 3'b000, 7'h00, 0, 1);
    checkOutput("late.wb", outVec, expWbAlu());

    // Reset in the middle of a store access.
    applyStimulus(1, OP_ST, 3'b010, 7'h00, 0, 1);
    applyStimulus(1, OP_ST, 3'b010, 7'h00, 0, 1);
    applyStimulus(1, OP_ST, 3'b010, 7'h00, 0, 1);
    applyStimulus(1, OP_ST, 3'b010, 7'h00, 0, 0);
    checkOutput("rstwr.wr", outVec,
                packOut(1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0, 2'b00));
    applyStimulus(0, OP_ST, 3'b010, 7'h00, 0, 0);
    applyStimulus(0, OP_ST, 3'b010, 7'h00, 0, 0);
    checkOutput("rstwr.held", outVec, 22'd0);
    applyStimulus(1, OP_ST, 3'b010, 7'h00, 0, 0);
    checkOutput("rstwr.release", outVec, expFetch(0));

    // Illegal R-type modifier traps after EXEC_R and stays trapped.
    applyStimulus(1, OP_R, 3'b000, 7'h01, 0, 1);
    applyStimulus(1, OP_R, 3'b000, 7'h01, 0, 1);
    applyStimulus(1, OP_R, 3'b000, 7'h01, 0, 1);
    applyStimulus(1, OP_R, 3'b000, 7'h01, 0, 1);
    checkOutput("illr.trap", outVec, expTrap(2'b01));
    applyStimulus(1, OP_R, 3'b000, 7'h00, 1, 1);
    checkOutput("illr.sticky", outVec, expTrap(2'b01));
    doReset();

    // Unknown opcode traps straight out of DECODE.
    applyStimulus(1, OP_BAD, 3'b000, 7'h00, 0, 1);
    applyStimulus(1, OP_BAD, 3'b000, 7'h00, 0, 1);
    checkOutput("illop.decode", outVec, expDecode(0));
    applyStimulus(1, OP_BAD, 3'b000, 7'h00, 0, 1);
    checkOutput("illop.trap", outVec, expTrap(2'b01));
    doReset();

    // Fetch never completes: trap with bus-timeout cause after 16 waiting cycles.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1, OP_R, 3'b000, 7'h00, 0, 0);
      if (i == 1 || i == 16) checkOutput($sformatf("tmo.fetch%0d", i), outVec, expFetch(0));
    end
    applyStimulus(1, OP_R, 3'b000, 7'h00, 0, 0);
    checkOutput("tmo.trap", outVec, expTrap(2'b10));
    applyStimulus(1, OP_R, 3'b000, 7'h00, 0, 1);
    checkOutput("tmo.sticky", outVec, expTrap(2'b10));
    doReset();
    applyStimulus(1, OP_R, 3'b000, 7'h00, 0, 0);
    checkOutput("tmo.cleared", outVec, expFetch(0));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
